// File: rtl/drac_pkg.sv
// Shared sizing and types for the DRAC vector datapath (rename -> rr_stage -> SIMD issue).
package drac_pkg;

  localparam int unsigned DRAC_NUM_PREGS = 64;
  localparam int unsigned DRAC_VLEN      = 128;
  localparam int unsigned DRAC_MASK_W    = 16;

  localparam int unsigned VRF_NUM_WR = 2;
  localparam int unsigned VRF_NUM_RD = 3;

  typedef logic [$clog2(DRAC_NUM_PREGS)-1:0] phvreg_t;
  typedef logic [DRAC_VLEN-1:0]              bus_simd_t;
  typedef logic [DRAC_MASK_W-1:0]            bus_mask_t;

  typedef struct packed {
    phvreg_t   addr;
    bus_simd_t data;
    logic      ready;
  } vrf_rd_port_t;

endpackage

// File: rtl/vregfile_bypass.sv
// Per-read-port bypass: forwards same-cycle writeback data and marks the operand ready.
module vregfile_bypass #(
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned PW     = 6,
  parameter int unsigned VLEN   = 128
) (
  input  logic [PW-1:0]          addr_i,
  input  logic [VLEN-1:0]        arr_data_i,
  input  logic                   arr_ready_i,
  input  logic [NUM_WR-1:0]      wr_en_i,
  input  logic [NUM_WR*PW-1:0]   wr_addr_i,
  input  logic [NUM_WR*VLEN-1:0] wr_data_i,
  output logic [VLEN-1:0]        data_o,
  output logic                   ready_o
);

  // Ascending scan so the highest matching write port wins.
  always_comb begin
    data_o  = arr_data_i;
    ready_o = arr_ready_i;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en_i[i] && (wr_addr_i[i*PW +: PW] == addr_i)) begin
        data_o  = wr_data_i[i*VLEN +: VLEN];
        ready_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vregfile_sb.sv
// Physical vector register file with ready scoreboard, write bypass, mask port and
// an optional registered read stage that can hold and snoop writebacks.
module vregfile_sb
  import drac_pkg::*;
#(
  parameter int unsigned NUM_WR    = VRF_NUM_WR,
  parameter int unsigned NUM_RD    = VRF_NUM_RD,
  parameter int unsigned NUM_ALLOC = 1,
  parameter int unsigned NUM_PREGS = DRAC_NUM_PREGS,
  parameter int unsigned VLEN      = DRAC_VLEN,
  parameter int unsigned MASK_W    = DRAC_MASK_W,
  parameter bit          READ_REG  = 1'b0,
  localparam int unsigned PW       = $clog2(NUM_PREGS)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [NUM_ALLOC-1:0]      alloc_valid_i,
  input  logic [NUM_ALLOC*PW-1:0]   alloc_preg_i,
  input  logic [NUM_WR-1:0]         wr_en_i,
  input  logic [NUM_WR*PW-1:0]      wr_addr_i,
  input  logic [NUM_WR*VLEN-1:0]    wr_data_i,
  input  logic [NUM_RD*PW-1:0]      rd_addr_i,
  input  logic [PW-1:0]             rdm_addr_i,
  input  logic                      use_mask_i,
  input  logic                      rd_hold_i,
  output logic [NUM_RD*VLEN-1:0]    rd_data_o,
  output logic [NUM_RD-1:0]         rd_ready_o,
  output logic [MASK_W-1:0]         rdm_data_o,
  output logic                      rdm_ready_o
);

  logic [VLEN-1:0]      mem_q [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready_q, ready_d;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en_i[i]) mem_q[wr_addr_i[i*PW +: PW]] <= wr_data_i[i*VLEN +: VLEN];
    end
  end

  // Allocation is applied after writeback so it wins on a same-preg collision.
  always_comb begin
    ready_d = ready_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en_i[i]) ready_d[wr_addr_i[i*PW +: PW]] = 1'b1;
    end
    for (int k = 0; k < NUM_ALLOC; k++) begin
      if (alloc_valid_i[k]) ready_d[alloc_preg_i[k*PW +: PW]] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ready_q <= '1;
    else         ready_q <= ready_d;
  end

  logic [NUM_RD-1:0][VLEN-1:0] byp_data;
  logic [NUM_RD-1:0]           byp_ready;

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [PW-1:0] addr;
    assign addr = rd_addr_i[r*PW +: PW];

    vregfile_bypass #(
      .NUM_WR (NUM_WR),
      .PW     (PW),
      .VLEN   (VLEN)
    ) u_byp (
      .addr_i      (addr),
      .arr_data_i  (mem_q[addr]),
      .arr_ready_i (ready_q[addr]),
      .wr_en_i     (wr_en_i),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .data_o      (byp_data[r]),
      .ready_o     (byp_ready[r])
    );
  end

  logic [VLEN-1:0]   mask_byp_data;
  logic              mask_byp_ready;
  logic [MASK_W-1:0] mask_data;
  logic              mask_ready;
  logic              unused_mask_hi;

  vregfile_bypass #(
    .NUM_WR (NUM_WR),
    .PW     (PW),
    .VLEN   (VLEN)
  ) u_byp_mask (
    .addr_i      (rdm_addr_i),
    .arr_data_i  (mem_q[rdm_addr_i]),
    .arr_ready_i (ready_q[rdm_addr_i]),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .data_o      (mask_byp_data),
    .ready_o     (mask_byp_ready)
  );

  // An unused mask reads as "all lanes active" and never stalls issue.
  assign mask_data      = use_mask_i ? mask_byp_data[MASK_W-1:0] : '1;
  assign mask_ready     = use_mask_i ? mask_byp_ready : 1'b1;
  assign unused_mask_hi = ^mask_byp_data;

  if (READ_REG) begin : g_rd_reg
    logic [NUM_RD-1:0][PW-1:0]   addr_q, addr_d;
    logic [NUM_RD-1:0][VLEN-1:0] data_q, data_d;
    logic [NUM_RD-1:0]           rdy_q, rdy_d;
    logic [PW-1:0]               maddr_q, maddr_d;
    logic [MASK_W-1:0]           mdata_q, mdata_d;
    logic                        mrdy_q, mrdy_d;
    logic                        muse_q, muse_d;

    always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      rdy_d   = rdy_q;
      maddr_d = maddr_q;
      mdata_d = mdata_q;
      mrdy_d  = mrdy_q;
      muse_d  = muse_q;
      if (!rd_hold_i) begin
        for (int r = 0; r < NUM_RD; r++) begin
          addr_d[r] = rd_addr_i[r*PW +: PW];
          data_d[r] = byp_data[r];
          rdy_d[r]  = byp_ready[r];
        end
        maddr_d = rdm_addr_i;
        muse_d  = use_mask_i;
        mdata_d = mask_data;
        mrdy_d  = mask_ready;
      end else begin
        // Held operands still pick up their writeback so the consumer never misses it.
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_en_i[i]) begin
            for (int r = 0; r < NUM_RD; r++) begin
              if (wr_addr_i[i*PW +: PW] == addr_q[r]) begin
                data_d[r] = wr_data_i[i*VLEN +: VLEN];
                rdy_d[r]  = 1'b1;
              end
            end
            if (muse_q && (wr_addr_i[i*PW +: PW] == maddr_q)) begin
              mdata_d = wr_data_i[i*VLEN +: MASK_W];
              mrdy_d  = 1'b1;
            end
          end
        end
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        addr_q  <= '0;
        data_q  <= '0;
        rdy_q   <= '0;
        maddr_q <= '0;
        mdata_q <= '0;
        mrdy_q  <= 1'b0;
        muse_q  <= 1'b0;
      end else begin
        addr_q  <= addr_d;
        data_q  <= data_d;
        rdy_q   <= rdy_d;
        maddr_q <= maddr_d;
        mdata_q <= mdata_d;
        mrdy_q  <= mrdy_d;
        muse_q  <= muse_d;
      end
    end

    assign rd_data_o   = data_q;
    assign rd_ready_o  = rdy_q;
    assign rdm_data_o  = mdata_q;
    assign rdm_ready_o = mrdy_q;
  end else begin : g_rd_comb
    logic unused_hold;
    assign unused_hold = rd_hold_i;

    assign rd_data_o   = byp_data;
    assign rd_ready_o  = byp_ready;
    assign rdm_data_o  = mask_data;
    assign rdm_ready_o = mask_ready;
  end

  logic wr_conflict;
  always_comb begin
    wr_conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en_i[i] && wr_en_i[j] && (wr_addr_i[i*PW +: PW] == wr_addr_i[j*PW +: PW])) begin
          wr_conflict = 1'b1;
        end
      end
    end
  end

  a_no_dual_write : assert property (@(posedge clk_i) disable iff (!rstn_i) !wr_conflict)
    else $warning("vregfile_sb: two write ports target the same preg");

endmodule

// File: tb/tb_vregfile_sb.sv
// Bench for vregfile_sb: one combinational-read and one registered-read instance share stimulus.
module tb_vregfile_sb;

  localparam int unsigned P  = 64;
  localparam int unsigned PW = 6;
  localparam int unsigned VL = 128;
  localparam int unsigned MW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [0:0]    alloc_valid;
  logic [PW-1:0] alloc_preg;
  logic [1:0]    wr_en;
  logic [2*PW-1:0] wr_addr;
  logic [2*VL-1:0] wr_data;
  logic [3*PW-1:0] rd_addr;
  logic [PW-1:0] rdm_addr;
  logic          use_mask, rd_hold;

  logic [3*VL-1:0] c_rd_data, r_rd_data;
  logic [2:0]      c_rd_ready, r_rd_ready;
  logic [MW-1:0]   c_rdm_data, r_rdm_data;
  logic            c_rdm_ready, r_rdm_ready;

  always #5 clk = ~clk;

  vregfile_sb #(.READ_REG(1'b0)) u_comb (
    .clk_i(clk), .rstn_i(rstn), .alloc_valid_i(alloc_valid), .alloc_preg_i(alloc_preg),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd_addr_i(rd_addr),
    .rdm_addr_i(rdm_addr), .use_mask_i(use_mask), .rd_hold_i(rd_hold),
    .rd_data_o(c_rd_data), .rd_ready_o(c_rd_ready), .rdm_data_o(c_rdm_data),
    .rdm_ready_o(c_rdm_ready)
  );

  vregfile_sb #(.READ_REG(1'b1)) u_reg (
    .clk_i(clk), .rstn_i(rstn), .alloc_valid_i(alloc_valid), .alloc_preg_i(alloc_preg),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd_addr_i(rd_addr),
    .rdm_addr_i(rdm_addr), .use_mask_i(use_mask), .rd_hold_i(rd_hold),
    .rd_data_o(r_rd_data), .rd_ready_o(r_rd_ready), .rdm_data_o(r_rdm_data),
    .rdm_ready_o(r_rdm_ready)
  );

  // Reference model: architectural contents and ready flags, plus the held read stage.
  logic [VL-1:0] m_mem [P];
  bit            m_rdy [P];
  logic [VL-1:0] exp_c_data [3];
  bit            exp_c_rdy  [3];
  logic [MW-1:0] exp_c_mdata;
  bit            exp_c_mrdy;
  logic [VL-1:0] exp_r_data [3];
  bit            exp_r_rdy  [3];
  logic [MW-1:0] exp_r_mdata;
  bit            exp_r_mrdy;
  int            h_addr [3];
  int            h_maddr;
  bit            h_muse;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [VL-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Value a reader sees this cycle: a same-cycle write (last port wins) overrides the array.
  function automatic void lookup(input int a, output logic [VL-1:0] d, output bit rdy);
    d   = m_mem[a];
    rdy = m_rdy[a];
    for (int w = 0; w < 2; w++) begin
      if (wr_en[w] && int'(wr_addr[w*PW +: PW]) == a) begin
        d   = wr_data[w*VL +: VL];
        rdy = 1'b1;
      end
    end
  endfunction

  function automatic void model_eval();
    logic [VL-1:0] d;
    bit            rdy;
    for (int p = 0; p < 3; p++) begin
      lookup(int'(rd_addr[p*PW +: PW]), d, rdy);
      exp_c_data[p] = d;
      exp_c_rdy[p]  = rdy;
    end
    if (use_mask) begin
      lookup(int'(rdm_addr), d, rdy);
      exp_c_mdata = d[MW-1:0];
      exp_c_mrdy  = rdy;
    end else begin
      exp_c_mdata = 16'hFFFF;
      exp_c_mrdy  = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    for (int a = 0; a < P; a++) m_rdy[a] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      exp_r_data[p] = '0;
      exp_r_rdy[p]  = 1'b0;
      h_addr[p]     = 0;
    end
    exp_r_mdata = '0;
    exp_r_mrdy  = 1'b0;
    h_maddr     = 0;
    h_muse      = 1'b0;
  endfunction

  // Advance the model across one posedge using the inputs as currently driven.
  task automatic tick();
    model_eval();
    if (!rd_hold) begin
      for (int p = 0; p < 3; p++) begin
        h_addr[p]     = int'(rd_addr[p*PW +: PW]);
        exp_r_data[p] = exp_c_data[p];
        exp_r_rdy[p]  = exp_c_rdy[p];
      end
      h_maddr     = int'(rdm_addr);
      h_muse      = use_mask;
      exp_r_mdata = exp_c_mdata;
      exp_r_mrdy  = exp_c_mrdy;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (wr_en[w]) begin
          for (int p = 0; p < 3; p++) begin
            if (int'(wr_addr[w*PW +: PW]) == h_addr[p]) begin
              exp_r_data[p] = wr_data[w*VL +: VL];
              exp_r_rdy[p]  = 1'b1;
            end
          end
          if (h_muse && int'(wr_addr[w*PW +: PW]) == h_maddr) begin
            exp_r_mdata = wr_data[w*VL +: MW];
            exp_r_mrdy  = 1'b1;
          end
        end
      end
    end
    for (int w = 0; w < 2; w++) begin
      if (wr_en[w]) begin
        m_mem[wr_addr[w*PW +: PW]] = wr_data[w*VL +: VL];
        m_rdy[wr_addr[w*PW +: PW]] = 1'b1;
      end
    end
    if (alloc_valid[0]) m_rdy[alloc_preg] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = '0; alloc_preg = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; rdm_addr = '0; use_mask = 1'b0; rd_hold = 1'b0;
  endtask

  task automatic init_array();
    for (int a = 0; a < P; a += 2) begin
      idle_inputs();
      wr_en = 2'b11;
      wr_addr = {PW'(a + 1), PW'(a)};
      wr_data = {rnd128(), rnd128()};
      @(negedge clk);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_addr = {PW'(2), PW'(1), PW'(0)};
    use_mask = 1'b1; rdm_addr = 6'd3;
    alloc_valid = 1'b1; alloc_preg = 6'd5;
    @(negedge clk);
    tick();
    idle_inputs();
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (r_rd_data !== '0 || r_rd_ready !== 3'b000 || r_rdm_data !== '0 || r_rdm_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b mrdy=%b mdata=%h want all zero",
               r_rd_ready, r_rdm_ready, r_rdm_data);
    end
    rstn = 1'b1;
    rd_addr = {PW'(0), PW'(0), PW'(5)};
    @(negedge clk);
    n_checks++;
    if (c_rd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_comb: got %b want 1", c_rd_ready[0]);
    end
    tick();
    n_checks++;
    if (r_rd_ready[0] !== 1'b1 || r_rd_data[VL-1:0] !== m_mem[5]) begin
      n_fail++;
      $display("FAIL reset_ready_reg: got %b/%h want 1/%h", r_rd_ready[0], r_rd_data[VL-1:0], m_mem[5]);
    end
  endtask

  task automatic test_alloc_write();
    logic [VL-1:0] a5;
    a5 = {16{8'hA5}};
    idle_inputs();
    alloc_valid = 1'b1; alloc_preg = 6'd7; rd_addr[PW-1:0] = 6'd7;
    @(negedge clk);
    n_checks++;
    if (c_rd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL alloc_same_cycle_ready: got %b want 1", c_rd_ready[0]);
    end
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (c_rd_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_ready_comb: got %b want 0", c_rd_ready[0]);
    end
    tick();
    n_checks++;
    if (r_rd_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_ready_reg: got %b want 0", r_rd_ready[0]);
    end
    @(negedge clk);
    tick();
    wr_en = 2'b10; wr_addr[2*PW-1:PW] = 6'd7; wr_data[2*VL-1:VL] = a5;
    @(negedge clk);
    n_checks++;
    if (c_rd_data[VL-1:0] !== a5 || c_rd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_comb: got %h/%b want %h/1", c_rd_data[VL-1:0], c_rd_ready[0], a5);
    end
    tick();
    n_checks++;
    if (r_rd_data[VL-1:0] !== a5 || r_rd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_reg: got %h/%b want %h/1", r_rd_data[VL-1:0], r_rd_ready[0], a5);
    end
    wr_en = 2'b00;
    @(negedge clk);
    n_checks++;
    if (c_rd_data[VL-1:0] !== a5 || c_rd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL array_read: got %h/%b want %h/1", c_rd_data[VL-1:0], c_rd_ready[0], a5);
    end
    tick();
  endtask

  task automatic test_alloc_write_same();
    logic [VL-1:0] v;
    v = rnd128();
    idle_inputs();
    alloc_valid = 1'b1; alloc_preg = 6'd9;
    wr_en = 2'b01; wr_addr[PW-1:0] = 6'd9; wr_data[VL-1:0] = v;
    @(negedge clk);
    tick();
    idle_inputs();
    rd_addr[2*PW +: PW] = 6'd9;
    @(negedge clk);
    n_checks++;
    if (c_rd_data[2*VL +: VL] !== v || c_rd_ready[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_wins_comb: got %h/%b want %h/0", c_rd_data[2*VL +: VL], c_rd_ready[2], v);
    end
    tick();
    n_checks++;
    if (r_rd_data[2*VL +: VL] !== v || r_rd_ready[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_wins_reg: got %h/%b want %h/0", r_rd_data[2*VL +: VL], r_rd_ready[2], v);
    end
  endtask

  task automatic test_conflict();
    idle_inputs();
    wr_en = 2'b11; wr_addr = {PW'(3), PW'(3)};
    wr_data = {VL'(2), VL'(1)};
    rd_addr[PW +: PW] = 6'd3;
    @(negedge clk);
    n_checks++;
    if (c_rd_data[VL +: VL] !== VL'(2)) begin
      n_fail++;
      $display("FAIL conflict_bypass: got %h want 2", c_rd_data[VL +: VL]);
    end
    tick();
    wr_en = 2'b00;
    @(negedge clk);
    n_checks++;
    if (c_rd_data[VL +: VL] !== VL'(2)) begin
      n_fail++;
      $display("FAIL conflict_array: got %h want 2", c_rd_data[VL +: VL]);
    end
    tick();
  endtask

  task automatic test_mask();
    idle_inputs();
    rdm_addr = 6'd4;
    @(negedge clk);
    n_checks++;
    if (c_rdm_data !== 16'hFFFF || c_rdm_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_off_comb: got %h/%b want ffff/1", c_rdm_data, c_rdm_ready);
    end
    tick();
    n_checks++;
    if (r_rdm_data !== 16'hFFFF || r_rdm_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_off_reg: got %h/%b want ffff/1", r_rdm_data, r_rdm_ready);
    end
    wr_en = 2'b01; wr_addr[PW-1:0] = 6'd4; wr_data[VL-1:0] = {112'h1234, 16'h00F0};
    @(negedge clk);
    tick();
    wr_en = 2'b00; use_mask = 1'b1;
    @(negedge clk);
    n_checks++;
    if (c_rdm_data !== 16'h00F0 || c_rdm_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_on_comb: got %h/%b want 00f0/1", c_rdm_data, c_rdm_ready);
    end
    tick();
    n_checks++;
    if (r_rdm_data !== 16'h00F0) begin
      n_fail++;
      $display("FAIL mask_on_reg: got %h want 00f0", r_rdm_data);
    end
  endtask

  task automatic test_hold_snoop();
    logic [VL-1:0] held, v55;
    v55 = {16{8'h55}};
    idle_inputs();
    alloc_valid = 1'b1; alloc_preg = 6'd12;
    @(negedge clk);
    tick();
    idle_inputs();
    rd_addr[PW-1:0] = 6'd12;
    @(negedge clk);
    tick();
    held = m_mem[12];
    n_checks++;
    if (r_rd_ready[0] !== 1'b0 || r_rd_data[VL-1:0] !== held) begin
      n_fail++;
      $display("FAIL hold_capture: got %h/%b want %h/0", r_rd_data[VL-1:0], r_rd_ready[0], held);
    end
    rd_hold = 1'b1; rd_addr[PW-1:0] = 6'd20;
    wr_en = 2'b01; wr_addr[PW-1:0] = 6'd13; wr_data[VL-1:0] = rnd128();
    @(negedge clk);
    tick();
    n_checks++;
    if (r_rd_ready[0] !== 1'b0 || r_rd_data[VL-1:0] !== held) begin
      n_fail++;
      $display("FAIL hold_other_write: got %h/%b want %h/0", r_rd_data[VL-1:0], r_rd_ready[0], held);
    end
    wr_en = 2'b10; wr_addr[2*PW-1:PW] = 6'd12; wr_data[2*VL-1:VL] = v55;
    @(negedge clk);
    tick();
    n_checks++;
    if (r_rd_ready[0] !== 1'b1 || r_rd_data[VL-1:0] !== v55) begin
      n_fail++;
      $display("FAIL hold_snoop: got %h/%b want %h/1", r_rd_data[VL-1:0], r_rd_ready[0], v55);
    end
    wr_en = 2'b00;
    @(negedge clk);
    tick();
    n_checks++;
    if (r_rd_ready[0] !== 1'b1 || r_rd_data[VL-1:0] !== v55) begin
      n_fail++;
      $display("FAIL hold_keep: got %h/%b want %h/1", r_rd_data[VL-1:0], r_rd_ready[0], v55);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int a0;
    for (int c = 0; c < 300; c++) begin
      alloc_valid = 1'(($urandom % 4) == 0);
      alloc_preg  = PW'($urandom % 16);
      wr_en       = 2'($urandom);
      a0          = int'($urandom % 16);
      wr_addr     = {PW'((a0 + 1 + int'($urandom % 15)) % 16), PW'(a0)};
      wr_data     = {rnd128(), rnd128()};
      for (int p = 0; p < 3; p++) rd_addr[p*PW +: PW] = PW'($urandom % 16);
      rdm_addr = PW'($urandom % 16);
      use_mask = 1'($urandom);
      rd_hold  = 1'(($urandom % 3) == 0);
      @(negedge clk);
      model_eval();
      for (int p = 0; p < 3; p++) begin
        n_checks++;
        if (c_rd_data[p*VL +: VL] !== exp_c_data[p] || c_rd_ready[p] !== exp_c_rdy[p]) begin
          n_fail++;
          $display("FAIL rand_comb cyc%0d port%0d: got %h/%b want %h/%b", c, p,
                   c_rd_data[p*VL +: VL], c_rd_ready[p], exp_c_data[p], exp_c_rdy[p]);
        end
      end
      n_checks++;
      if (c_rdm_data !== exp_c_mdata || c_rdm_ready !== exp_c_mrdy) begin
        n_fail++;
        $display("FAIL rand_comb_mask cyc%0d: got %h/%b want %h/%b", c, c_rdm_data, c_rdm_ready,
                 exp_c_mdata, exp_c_mrdy);
      end
      tick();
      for (int p = 0; p < 3; p++) begin
        n_checks++;
        if (r_rd_data[p*VL +: VL] !== exp_r_data[p] || r_rd_ready[p] !== exp_r_rdy[p]) begin
          n_fail++;
          $display("FAIL rand_reg cyc%0d port%0d: got %h/%b want %h/%b", c, p,
                   r_rd_data[p*VL +: VL], r_rd_ready[p], exp_r_data[p], exp_r_rdy[p]);
        end
      end
      n_checks++;
      if (r_rdm_data !== exp_r_mdata || r_rdm_ready !== exp_r_mrdy) begin
        n_fail++;
        $display("FAIL rand_reg_mask cyc%0d: got %h/%b want %h/%b", c, r_rdm_data, r_rdm_ready,
                 exp_r_mdata, exp_r_mrdy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    model_reset();
    #12;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    init_array();
    test_reset();
    test_alloc_write();
    test_alloc_write_same();
    test_conflict();
    test_mask();
    test_hold_snoop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
